// File: rtl/cart_loader_pkg.sv
// rtl/cart_loader_pkg.sv - shared types, constants and helpers for the cartridge loader
//
// Purpose : drain FSM state encoding, serial compare byte width and the
//           16-bit byte-swap used on the memory write path.
// Ports   : none (package).
package cart_loader_pkg;

  // Drain FSM: either nothing in flight, or one request waiting for its ack.
  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_e;

  // Width of one serial byte in the quirk compare; the full compare key is
  // ID_LEN of these.
  localparam int CMP_BYTE_W = 8;

  // The loader delivers the even byte in [7:0]; memory wants it in [15:8].
  function automatic logic [15:0] swap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/cart_loader_if.sv
// rtl/cart_loader_if.sv - loader-side and memory-side signal bundle for cart_loader
//
// Purpose : groups the ioctl download port, the toggle-handshake memory port
//           and the status outputs.
// Ports   : master - drives ioctl_* and mem_ack, observes everything else.
//           slave  - the cart_loader side.
interface cart_loader_if #(
  parameter int DW = 16,
  parameter int AW = 25,
  parameter int QW = 3
);
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [DW-1:0] ioctl_data;
  logic          ioctl_wait;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] rom_size;
  logic [QW-1:0] quirks;
  logic          overflow;
  logic          done;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, mem_ack,
    input  ioctl_wait, mem_addr, mem_din, mem_req, rom_size, quirks, overflow, done
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, mem_ack,
    output ioctl_wait, mem_addr, mem_din, mem_req, rom_size, quirks, overflow, done
  );
endinterface

// File: rtl/cart_loader_fifo.sv
// rtl/cart_loader_fifo.sv - synchronous write buffer with fill count
//
// Purpose : DEPTH-entry FIFO (DEPTH a power of two) with a combinational head.
// Ports   : clk_sys, reset (sync, active-high)
//           i_push/i_data  - write side, ignored when full
//           i_pop/o_data   - read side, o_data is the current head
//           o_count        - entries held; o_empty/o_full derived from it
module cart_loader_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cart_loader.sv
// rtl/cart_loader.sv - buffered cartridge download into toggle-handshake memory
//
// Purpose : accepts ioctl writes into a small FIFO, drains them one at a time
//           over a req/ack toggle handshake, tracks the loaded size, captures
//           the cartridge serial and maps it to quirk flags.
// Ports   : clk_sys  - system clock
//           reset    - synchronous active-high reset
//           bus      - cart_loader_if.slave: ioctl_* in / ioctl_wait out,
//                      mem_addr/mem_din/mem_req out, mem_ack in,
//                      rom_size/quirks/overflow/done status out
module cart_loader
  import cart_loader_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 25,
  parameter int DEPTH   = 4,
  parameter int ID_BASE = 'h183,
  parameter int ID_LEN  = 8,
  parameter int NQ      = 17,
  parameter int QW      = 3,
  parameter logic [NQ*ID_LEN*CMP_BYTE_W-1:0] QUIRK_IDS  = '0,
  parameter logic [NQ*QW-1:0]                QUIRK_MASK = '0
) (
  input  logic          clk_sys,
  input  logic          reset,
  cart_loader_if.slave  bus
);

  localparam int NB  = DW / 8;
  localparam int IDW = ID_LEN * CMP_BYTE_W;
  localparam int FW  = AW + DW;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] ID_FIRST = AW'(ID_BASE);
  localparam logic [AW-1:0] ID_LAST  = AW'(ID_BASE + ID_LEN - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          w_issue;
  logic          w_acked;

  logic          w_wr_ok;
  logic          w_push;
  logic          w_drop;
  logic [FW-1:0] w_head;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;
  logic [DW-1:0] w_din;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_empty;
  logic          w_full;

  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_din;
  logic          r_wait;

  logic          r_dl_prev;
  logic          w_rise;
  logic          w_fall;
  logic          w_pend;
  logic          w_done_now;
  logic          r_pend;
  logic          r_done;
  logic [AW-1:0] w_end_addr;
  logic [AW-1:0] r_rom_size;
  logic          r_overflow;

  logic [IDW-1:0] r_id;
  logic           w_hit_last;
  logic           r_cmp_go;
  logic           r_apply;
  logic [NQ-1:0]  w_match;
  logic [NQ-1:0]  r_match;
  logic [QW-1:0]  w_qor;
  logic [QW-1:0]  r_quirks;

  // Writes outside the download window never reach the buffer.
  assign w_wr_ok = bus.ioctl_download & bus.ioctl_wr;
  assign w_push  = w_wr_ok & ~w_full;
  assign w_drop  = w_wr_ok & w_full;

  cart_loader_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({bus.ioctl_addr, bus.ioctl_data}),
    .i_pop   (w_issue),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_head_addr = w_head[FW-1:DW];
  assign w_head_data = w_head[DW-1:0];

  if (DW == 16) begin : g_swap
    assign w_din = swap16(w_head_data);
  end else begin : g_noswap
    assign w_din = w_head_data;
  end

  // ---------------- drain FSM ----------------
  assign w_acked = (bus.mem_ack == r_mem_req);

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (!w_empty) w_state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: if (w_acked && w_empty) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // An ack that lands with more data queued issues the next entry in the
  // same cycle, so back-to-back transfers have no idle bubble.
  always_comb begin
    w_issue = 1'b0;
    case (r_state)
      ST_IDLE:     w_issue = ~w_empty;
      ST_WAIT_ACK: w_issue = w_acked & ~w_empty;
      default:     w_issue = 1'b0;
    endcase
  end

  // mem_addr/mem_din only move on an issue, which keeps them stable for the
  // whole time a request is outstanding. Reset re-aligns req with ack so no
  // phantom request is seen.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_mem_req  <= bus.mem_ack;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else if (w_issue) begin
      r_mem_req  <= ~r_mem_req;
      r_mem_addr <= w_head_addr;
      r_mem_din  <= w_din;
    end
  end

  // Back-pressure looks at the count after this cycle's push/pop so the
  // loader sees it one entry before the buffer is actually full.
  always_comb begin
    w_cnt_nxt = w_count;
    if (w_push && !w_issue)      w_cnt_nxt = w_count + 1'b1;
    else if (!w_push && w_issue) w_cnt_nxt = w_count - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) r_wait <= 1'b0;
    else       r_wait <= (w_cnt_nxt >= CW'(DEPTH - 1));
  end

  // ---------------- download status ----------------
  assign w_rise     = bus.ioctl_download & ~r_dl_prev;
  assign w_fall     = ~bus.ioctl_download & r_dl_prev;
  assign w_pend     = r_pend | w_fall;
  assign w_done_now = w_pend & ~bus.ioctl_download & w_empty & (r_state == ST_IDLE);
  assign w_end_addr = bus.ioctl_addr + AW'(NB);

  // A download start clears the status; a write in that same cycle still
  // counts, so its update is applied after the clear.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dl_prev  <= 1'b0;
      r_rom_size <= '0;
      r_overflow <= 1'b0;
      r_pend     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_dl_prev <= bus.ioctl_download;
      if (w_rise) r_rom_size <= '0;
      if (w_push && (w_rise || (w_end_addr > r_rom_size))) r_rom_size <= w_end_addr;
      if (w_rise) r_overflow <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      r_done <= w_done_now;
      r_pend <= w_rise ? 1'b0 : (w_pend & ~w_done_now);
    end
  end

  // ---------------- serial capture and quirk lookup ----------------
  always_comb begin
    w_hit_last = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (bus.ioctl_addr + AW'(b) == ID_LAST) w_hit_last = w_push;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_id <= '0;
    end else begin
      if (w_rise) r_id <= '0;
      if (w_push) begin
        for (int k = 0; k < ID_LEN; k++) begin
          for (int b = 0; b < NB; b++) begin
            if (bus.ioctl_addr + AW'(b) == ID_FIRST + AW'(k))
              r_id[IDW - CMP_BYTE_W*(k+1) +: CMP_BYTE_W] <= bus.ioctl_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    w_match = '0;
    w_qor   = '0;
    for (int i = 0; i < NQ; i++) begin
      w_match[i] = (r_id == QUIRK_IDS[i*IDW +: IDW]);
      if (r_match[i]) w_qor = w_qor | QUIRK_MASK[i*QW +: QW];
    end
  end

  // Two-stage lookup: compare all entries, then merge the masks.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cmp_go <= 1'b0;
      r_apply  <= 1'b0;
      r_match  <= '0;
      r_quirks <= '0;
    end else begin
      r_cmp_go <= w_hit_last;
      r_apply  <= r_cmp_go;
      if (r_cmp_go) r_match <= w_match;
      if (w_rise)       r_quirks <= '0;
      else if (r_apply) r_quirks <= w_qor;
    end
  end

  assign bus.ioctl_wait = r_wait;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_din    = r_mem_din;
  assign bus.mem_req    = r_mem_req;
  assign bus.rom_size   = r_rom_size;
  assign bus.quirks     = r_quirks;
  assign bus.overflow   = r_overflow;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_cart_loader.sv
// tb/tb_cart_loader.sv - directed self-checking bench for cart_loader
module tb_cart_loader;

  localparam int DW = 16;
  localparam int AW = 25;
  localparam int QW = 3;
  localparam int NQ = 17;

  function automatic logic [NQ*64-1:0] mk_ids();
    logic [NQ*64-1:0] r;
    r = '0;
    r[0*64  +: 64] = "SLPS0000";
    r[2*64  +: 64] = "T-081276";
    r[5*64  +: 64] = "00001009";
    r[11*64 +: 64] = "T-081276";
    return r;
  endfunction

  function automatic logic [NQ*QW-1:0] mk_masks();
    logic [NQ*QW-1:0] r;
    r = '0;
    r[0*QW  +: QW] = 3'b111;
    r[2*QW  +: QW] = 3'b001;
    r[5*QW  +: QW] = 3'b100;
    r[11*QW +: QW] = 3'b010;
    return r;
  endfunction

  localparam logic [NQ*64-1:0] IDS   = mk_ids();
  localparam logic [NQ*QW-1:0] MASKS = mk_masks();

  logic clk_sys;
  logic reset;
  int   n_tot;
  int   n_bad;
  int   n_req;
  logic [AW-1:0] last_addr;

  cart_loader_if #(.DW(DW), .AW(AW), .QW(QW)) bus ();

  cart_loader #(
    .DW(DW), .AW(AW), .DEPTH(4), .ID_BASE('h183), .ID_LEN(8), .NQ(NQ), .QW(QW),
    .QUIRK_IDS(IDS), .QUIRK_MASK(MASKS)
  ) u_dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    step();
    bus.ioctl_wr   = 1'b0;
  endtask

  // Acks every outstanding request within a fixed cycle budget.
  task automatic drain(output int n, output logic [AW-1:0] last);
    n    = 0;
    last = '0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_req !== bus.mem_ack) begin
        n++;
        last        = bus.mem_addr;
        bus.mem_ack = bus.mem_req;
      end
      step();
    end
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_data     = '0;
    bus.mem_ack        = 1'b0;
    step();
    step();
    chk("rst_req",  bus.mem_req,    1'b0);
    chk("rst_wait", bus.ioctl_wait, 1'b0);
    chk("rst_rom",  bus.rom_size,   0);
    chk("rst_qrk",  bus.quirks,     0);
    chk("rst_ovf",  bus.overflow,   1'b0);
    chk("rst_done", bus.done,       1'b0);
    chk("rst_addr", bus.mem_addr,   0);
    reset = 1'b0;

    // single write, swapped data, late ack, done after download falls
    bus.ioctl_download = 1'b1;
    step();
    wr('h000, 16'h1234);
    chk("s1_req_t0", bus.mem_req,  1'b0);
    chk("s1_rom",    bus.rom_size, 2);
    step();
    chk("s1_req_t1", bus.mem_req,  1'b1);
    chk("s1_addr",   bus.mem_addr, 0);
    chk("s1_din",    bus.mem_din,  16'h3412);
    step(); step(); step();
    chk("s1_hold",   bus.mem_req,  1'b1);
    bus.mem_ack = 1'b1;
    step();
    chk("s1_nodone", bus.done, 1'b0);
    bus.ioctl_download = 1'b0;
    step();
    chk("s1_done",   bus.done, 1'b1);
    step();
    chk("s1_done1",  bus.done, 1'b0);

    // back-pressure and overflow with ack withheld
    bus.ioctl_download = 1'b1;
    step();
    wr('h010, 16'h0001);
    wr('h012, 16'h0002);
    chk("s2_issue",  bus.mem_addr,   'h10);
    wr('h014, 16'h0003);
    chk("s2_wait0",  bus.ioctl_wait, 1'b0);
    wr('h016, 16'h0004);
    chk("s2_wait1",  bus.ioctl_wait, 1'b1);
    wr('h018, 16'h0005);
    chk("s2_ovf0",   bus.overflow,   1'b0);
    wr('h01A, 16'h0006);
    chk("s2_ovf1",   bus.overflow,   1'b1);
    chk("s2_rom",    bus.rom_size,   'h1A);
    chk("s2_stable", bus.mem_addr,   'h10);
    drain(n_req, last_addr);
    chk("s2_nreq",   n_req,          5);
    chk("s2_last",   last_addr,      'h18);
    chk("s2_wait_e", bus.ioctl_wait, 1'b0);
    chk("s2_ovf_st", bus.overflow,   1'b1);
    bus.ioctl_download = 1'b0;
    step();
    chk("s2_done",   bus.done, 1'b1);

    // header "00001009" -> entry 5
    bus.ioctl_download = 1'b1;
    step();
    chk("s3_ovf_clr", bus.overflow, 1'b0);
    chk("s3_rom_clr", bus.rom_size, 0);
    wr('h182, 16'h3000);
    wr('h184, 16'h3030);
    wr('h186, 16'h3130);
    wr('h188, 16'h3030);
    wr('h18A, 16'h0039);
    step();
    chk("s3_qrk_t1", bus.quirks, 3'b000);
    step();
    chk("s3_qrk_t2", bus.quirks, 3'b100);
    chk("s3_ovf",    bus.overflow, 1'b0);
    drain(n_req, last_addr);
    chk("s3_nreq",   n_req, 5);
    chk("s3_rom",    bus.rom_size, 'h18C);

    // restart clears status; partial then full "T-081276" -> entries 2 and 11
    bus.ioctl_download = 1'b0;
    step();
    bus.ioctl_download = 1'b1;
    step();
    chk("s4_qrk_clr", bus.quirks,   3'b000);
    chk("s4_rom_clr", bus.rom_size, 0);
    chk("s4_ovf_clr", bus.overflow, 1'b0);
    wr('h182, 16'h5400);
    wr('h184, 16'h302D);
    wr('h186, 16'h3138);
    wr('h188, 16'h3732);
    step(); step(); step();
    chk("s4_partial", bus.quirks, 3'b000);
    wr('h18A, 16'h0036);
    step();
    step();
    chk("s4_qrk",    bus.quirks, 3'b011);
    drain(n_req, last_addr);
    chk("s4_nreq",   n_req, 5);

    // writes outside the download window are ignored
    bus.ioctl_download = 1'b0;
    step();
    wr('h400, 16'hBEEF);
    step();
    chk("ign_rom",   bus.rom_size, 'h18C);
    chk("ign_req",   bus.mem_req,  bus.mem_ack);

    // reset while waiting for an ack
    bus.ioctl_download = 1'b1;
    step();
    wr('h020, 16'h0011);
    wr('h022, 16'h0022);
    wr('h024, 16'h0033);
    wr('h026, 16'h0044);
    chk("s5_wait_pre", bus.ioctl_wait, 1'b1);
    bus.mem_ack = 1'b1;
    reset       = 1'b1;
    step();
    chk("s5_req",    bus.mem_req,    1'b1);
    chk("s5_wait",   bus.ioctl_wait, 1'b0);
    chk("s5_rom",    bus.rom_size,   0);
    reset = 1'b0;
    step(); step(); step(); step(); step();
    chk("s5_noreq",  bus.mem_req,    1'b1);
    chk("s5_wait_q", bus.ioctl_wait, 1'b0);
    bus.ioctl_download = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
